// File: rtl/cpu_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cpu_controller
//  Purpose  : Moore FSM sequencing the 16-bit RISC datapath (fetch, PC update,
//             decode, execute). MEM_WAIT adds memory wait cycles; define
//             CPU_BRANCH_EN to enable the conditional branch instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_controller #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [2:0] opcode_i,
    input  logic [1:0] op_i,
    input  logic [2:0] cond_i,
    input  logic [2:0] status_i,
    output logic [2:0] nsel_o,
    output logic [1:0] vsel_o,
    output logic       loada_o,
    output logic       loadb_o,
    output logic       loadc_o,
    output logic       loads_o,
    output logic       write_o,
    output logic       asel_o,
    output logic       bsel_o,
    output logic       load_ir_o,
    output logic       load_pc_o,
    output logic       reset_pc_o,
    output logic       addr_sel_o,
    output logic       load_addr_o,
    output logic       pc_sel_o,
    output logic [1:0] mem_cmd_o,
    output logic       halted_o
);

    localparam logic [2:0] WAIT_MAX  = 3'(MEM_WAIT);
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WR_IMM, S_GET_A, S_GET_B,
        S_ALU, S_ALU_MOV, S_WR_RD, S_CMP, S_ADDR, S_LD_ADDR, S_LD_MEM1,
        S_LD_MEM2, S_ST_B, S_ST_PASS, S_ST_MEM, S_HALT, S_BR, S_BR_TK, S_BR_NT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       br_taken;

`ifdef CPU_BRANCH_EN
    // status is {Z,V,N}; signed less-than is N != V
    always_comb begin
        br_taken = 1'b0;
        case (cond_i)
            3'b000:  br_taken = 1'b1;
            3'b001:  br_taken = status_i[2];
            3'b010:  br_taken = !status_i[2];
            3'b011:  br_taken = status_i[0] ^ status_i[1];
            3'b100:  br_taken = (status_i[0] ^ status_i[1]) | status_i[2];
            default: br_taken = 1'b0;
        endcase
    end
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{cond_i, status_i};
    assign br_taken = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_IF1;
            S_IF1: if (cnt_q == WAIT_MAX) state_d = S_IF2;
            S_IF2: state_d = S_UPD;
            S_UPD: state_d = S_DEC;
            S_DEC: begin
                case ({opcode_i, op_i})
                    5'b110_10:            state_d = S_WR_IMM;
                    5'b110_00, 5'b101_11: state_d = S_GET_B;
                    5'b101_00, 5'b101_10, 5'b101_01,
                    5'b011_00, 5'b100_00: state_d = S_GET_A;
                    5'b111_00:            state_d = S_HALT;
`ifdef CPU_BRANCH_EN
                    5'b001_00:            state_d = S_BR;
`endif
                    default:              state_d = S_IF1;
                endcase
            end
            // IR is stable after IF2, so later dispatch can re-read opcode/op
            S_GET_A:   state_d = (opcode_i == 3'b101) ? S_GET_B : S_ADDR;
            S_GET_B: begin
                if ({opcode_i, op_i} == 5'b110_00)      state_d = S_ALU_MOV;
                else if ({opcode_i, op_i} == 5'b101_01) state_d = S_CMP;
                else                                    state_d = S_ALU;
            end
            S_ALU, S_ALU_MOV:           state_d = S_WR_RD;
            S_WR_RD, S_WR_IMM, S_CMP:   state_d = S_IF1;
            S_ADDR:    state_d = S_LD_ADDR;
            S_LD_ADDR: state_d = (opcode_i == 3'b011) ? S_LD_MEM1 : S_ST_B;
            S_LD_MEM1: if (cnt_q == WAIT_MAX) state_d = S_LD_MEM2;
            S_LD_MEM2: state_d = S_IF1;
            S_ST_B:    state_d = S_ST_PASS;
            S_ST_PASS: state_d = S_ST_MEM;
            S_ST_MEM:  state_d = S_IF1;
            S_HALT:    state_d = S_HALT;
            S_BR:      state_d = br_taken ? S_BR_TK : S_BR_NT;
            S_BR_TK, S_BR_NT: state_d = S_IF1;
            default:   state_d = S_RST;
        endcase
    end

    // Wait counter runs only while a wait state holds; any transition clears it
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_IF1 || state_q == S_LD_MEM1) && state_d == state_q
            && cnt_q != WAIT_MAX) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_comb begin
        nsel_o      = '0;
        vsel_o      = '0;
        loada_o     = 1'b0;
        loadb_o     = 1'b0;
        loadc_o     = 1'b0;
        loads_o     = 1'b0;
        write_o     = 1'b0;
        asel_o      = 1'b0;
        bsel_o      = 1'b0;
        load_ir_o   = 1'b0;
        load_pc_o   = 1'b0;
        reset_pc_o  = 1'b0;
        addr_sel_o  = 1'b0;
        load_addr_o = 1'b0;
        pc_sel_o    = 1'b0;
        mem_cmd_o   = '0;
        halted_o    = 1'b0;
        case (state_q)
            S_RST:     begin reset_pc_o = 1'b1; load_pc_o = 1'b1; end
            S_IF1:     begin addr_sel_o = 1'b1; mem_cmd_o = MEM_READ; end
            S_IF2:     begin addr_sel_o = 1'b1; mem_cmd_o = MEM_READ; load_ir_o = 1'b1; end
            S_UPD:     load_pc_o = 1'b1;
            S_WR_IMM:  begin nsel_o = NSEL_RN; vsel_o = 2'b10; write_o = 1'b1; end
            S_GET_A:   begin nsel_o = NSEL_RN; loada_o = 1'b1; end
            S_GET_B:   begin nsel_o = NSEL_RM; loadb_o = 1'b1; end
            S_ALU:     loadc_o = 1'b1;
            S_ALU_MOV: begin loadc_o = 1'b1; asel_o = 1'b1; end
            S_WR_RD:   begin nsel_o = NSEL_RD; write_o = 1'b1; end
            S_CMP:     loads_o = 1'b1;
            S_ADDR:    begin bsel_o = 1'b1; loadc_o = 1'b1; end
            S_LD_ADDR: load_addr_o = 1'b1;
            S_LD_MEM1: mem_cmd_o = MEM_READ;
            S_LD_MEM2: begin
                mem_cmd_o = MEM_READ;
                nsel_o    = NSEL_RD;
                vsel_o    = 2'b01;
                write_o   = 1'b1;
            end
            S_ST_B:    begin nsel_o = NSEL_RD; loadb_o = 1'b1; end
            S_ST_PASS: begin asel_o = 1'b1; loadc_o = 1'b1; end
            S_ST_MEM:  mem_cmd_o = MEM_WRITE;
            S_HALT:    halted_o = 1'b1;
`ifdef CPU_BRANCH_EN
            S_BR_TK:   begin pc_sel_o = 1'b1; load_pc_o = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_controller
//  Purpose  : Random-instruction bench for cpu_controller against a per-cycle
//             expected control trace derived from the instruction sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    localparam int WAIT = 2;

    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada, loadb, loadc, loads, write, asel, bsel;
        logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, pc_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } out_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic [2:0] opcode = '0;
    logic [1:0] op     = '0;
    logic [2:0] cond   = '0;
    logic [2:0] status = '0;

    logic [2:0] nsel;
    logic [1:0] vsel, mem_cmd;
    logic loada, loadb, loadc, loads, write, asel, bsel;
    logic load_ir, load_pc, reset_pc, addr_sel, load_addr, pc_sel, halted;

    cpu_controller #(.MEM_WAIT(WAIT)) dut (
        .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .op_i(op),
        .cond_i(cond), .status_i(status), .nsel_o(nsel), .vsel_o(vsel),
        .loada_o(loada), .loadb_o(loadb), .loadc_o(loadc), .loads_o(loads),
        .write_o(write), .asel_o(asel), .bsel_o(bsel), .load_ir_o(load_ir),
        .load_pc_o(load_pc), .reset_pc_o(reset_pc), .addr_sel_o(addr_sel),
        .load_addr_o(load_addr), .pc_sel_o(pc_sel), .mem_cmd_o(mem_cmd),
        .halted_o(halted)
    );

    always #5 clk = ~clk;

    out_t obs;
    assign obs = {nsel, vsel, loada, loadb, loadc, loads, write, asel, bsel,
                  load_ir, load_pc, reset_pc, addr_sel, load_addr, pc_sel,
                  mem_cmd, halted};

    int    n_total = 0;
    int    n_bad   = 0;
    out_t  exp_q[$];
    string tag_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (opcode=%b op=%b)", tag, got, exp, opcode, op);
        end
    endtask

    task automatic push(input string t, input out_t o);
        exp_q.push_back(o);
        tag_q.push_back(t);
    endtask

    function automatic bit br_taken(input logic [2:0] c, input logic [2:0] s);
        bit z  = s[2];
        bit lt = (s[0] != s[1]);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return lt;
            3'd4:    return lt || z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic get_a();
        out_t o = '0; o.nsel = 3'b100; o.loada = 1'b1; push("GET_A", o);
    endtask
    task automatic get_b();
        out_t o = '0; o.nsel = 3'b001; o.loadb = 1'b1; push("GET_B", o);
    endtask
    task automatic alu(input bit a);
        out_t o = '0; o.loadc = 1'b1; o.asel = a; push("ALU", o);
    endtask
    task automatic wr_rd();
        out_t o = '0; o.nsel = 3'b010; o.write = 1'b1; push("WR_RD", o);
    endtask
    task automatic addr_steps();
        out_t o = '0; o.bsel = 1'b1; o.loadc = 1'b1; push("ADDR", o);
        o = '0; o.load_addr = 1'b1; push("LD_ADDR", o);
    endtask

    // Expected control vector for every cycle from IF1 until the next IF1
    task automatic build_trace(input logic [2:0] oc, input logic [1:0] o2,
                               input logic [2:0] c, input logic [2:0] s, output bit is_halt);
        out_t o;
        is_halt = 1'b0;
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i <= WAIT; i++) begin
            o = '0; o.addr_sel = 1'b1; o.mem_cmd = 2'b01; push("IF1", o);
        end
        o = '0; o.addr_sel = 1'b1; o.mem_cmd = 2'b01; o.load_ir = 1'b1; push("IF2", o);
        o = '0; o.load_pc = 1'b1; push("UPD", o);
        o = '0; push("DEC", o);
        case ({oc, o2})
            5'b110_10: begin o = '0; o.nsel = 3'b100; o.vsel = 2'b10; o.write = 1'b1; push("WR_IMM", o); end
            5'b110_00: begin get_b(); alu(1'b1); wr_rd(); end
            5'b101_00, 5'b101_10: begin get_a(); get_b(); alu(1'b0); wr_rd(); end
            5'b101_01: begin get_a(); get_b(); o = '0; o.loads = 1'b1; push("CMP", o); end
            5'b101_11: begin get_b(); alu(1'b0); wr_rd(); end
            5'b011_00: begin
                get_a(); addr_steps();
                for (int i = 0; i <= WAIT; i++) begin
                    o = '0; o.mem_cmd = 2'b01; push("LD_MEM1", o);
                end
                o = '0; o.mem_cmd = 2'b01; o.nsel = 3'b010; o.vsel = 2'b01; o.write = 1'b1;
                push("LD_MEM2", o);
            end
            5'b100_00: begin
                get_a(); addr_steps();
                o = '0; o.nsel = 3'b010; o.loadb = 1'b1; push("ST_B", o);
                o = '0; o.asel = 1'b1; o.loadc = 1'b1; push("ST_PASS", o);
                o = '0; o.mem_cmd = 2'b10; push("ST_MEM", o);
            end
            5'b111_00: begin
                is_halt = 1'b1;
                for (int i = 0; i < 20; i++) begin
                    o = '0; o.halted = 1'b1; push("HALT", o);
                end
            end
`ifdef CPU_BRANCH_EN
            5'b001_00: begin
                o = '0; push("BR", o);
                o = '0;
                if (br_taken(c, s)) begin o.pc_sel = 1'b1; o.load_pc = 1'b1; end
                push("BR_RES", o);
            end
`endif
            default: ;
        endcase
    endtask

    task automatic do_reset();
        out_t o = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        o.reset_pc = 1'b1; o.load_pc = 1'b1;
        check_eq("RST", 32'(obs), 32'(o));
        @(posedge clk); #1;
    endtask

    // Entered with the DUT in IF1; leaves it in IF1 (or after reset)
    task automatic run_instr(input logic [2:0] oc, input logic [1:0] o2,
                             input logic [2:0] c, input logic [2:0] s, input int rst_at);
        bit h;
        opcode = oc; op = o2; cond = c; status = s;
        build_trace(oc, o2, c, s, h);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == rst_at) begin
                do_reset();
                return;
            end
            check_eq(tag_q[k], 32'(obs), 32'(exp_q[k]));
            @(posedge clk); #1;
        end
        if (h) do_reset();
    endtask

    logic [4:0] enc_tab [9] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01,
                                5'b101_10, 5'b101_11, 5'b011_00, 5'b100_00, 5'b001_00};

    initial begin
        logic [4:0] e;
        int         r;
        #1;
        do_reset();
        run_instr(3'b110, 2'b10, 3'd0, 3'd0, -1);          // MOV R3,#7
        run_instr(3'b101, 2'b00, 3'd0, 3'd0, -1);          // ADD
        run_instr(3'b101, 2'b01, 3'd0, 3'd0, -1);          // CMP
        run_instr(3'b011, 2'b00, 3'd0, 3'd0, -1);          // LDR with waits
        run_instr(3'b100, 2'b00, 3'd0, 3'd0, -1);          // STR
        run_instr(3'b100, 2'b00, 3'd0, 3'd0, WAIT + 7);    // reset in ST_B
        run_instr(3'b011, 2'b00, 3'd0, 3'd0, WAIT + 8);    // reset mid LD_MEM1 wait
        run_instr(3'b011, 2'b00, 3'd0, 3'd0, -1);
        run_instr(3'b101, 2'b00, 3'd0, 3'd0, 1);           // reset mid IF1 wait
        run_instr(3'b001, 2'b00, 3'b010, 3'b100, -1);      // BNE with Z=1
        run_instr(3'b111, 2'b00, 3'd0, 3'd0, -1);          // HALT
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 7) e = enc_tab[$urandom_range(0, 8)];
            else                          e = 5'($urandom);
            r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_instr(e[4:2], e[1:0], 3'($urandom), 3'($urandom), r);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
